mdr_unit: RTL and testbench
===========================

MDR_UNIT -- requirements
Module: mdr_unit

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16 (minimum 8), setting the width of the data register and of all data ports.
REQ-002 The block SHALL have parameter TIMEOUT, default 15 (minimum 1), setting the maximum number of cycles spent in a memory wait state.
REQ-003 The block SHALL have a single clock and an asynchronous, active-high reset, with the ports listed as follows:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- z  in  DATA_W  internal bus source for loads.
- ld_mdr_z  in  1  load z into the register.
- rd_start  in  1  start a memory read.
- wr_start  in  1  start a memory write.
- byte_mode  in  1  byte transfer, captured at start.
- sign_ext  in  1  sign-extend a byte read, captured at start.
- mem_ready  in  1  memory completion strobe.
- mem_data_out  in  DATA_W  read data from memory.
- t_mdr_x  in  1  drive the register onto x.
- x  out  DATA_W  register value, or 0.
- mem_data_in  out  DATA_W  write data to memory.
- mem_rd  out  1  read request.
- mem_wr  out  1  write request.
- busy  out  1  high when not in IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle timeout pulse.
- mdr_q  out  DATA_W  current register value.

Function
REQ-004 The FSM SHALL have three states: IDLE, RD_WAIT and WR_WAIT, and all outputs other than x and mdr_q SHALL be registered or decoded from the registered state.
REQ-005 In IDLE, rd_start SHALL move the FSM to RD_WAIT at the next edge; otherwise wr_start SHALL move it to WR_WAIT. rd_start wins if both are asserted, and the write is dropped.
REQ-006 byte_mode and sign_ext SHALL be captured on the edge that leaves IDLE and SHALL be held for the whole transfer.
REQ-007 mem_rd SHALL be 1 exactly while in RD_WAIT, mem_wr SHALL be 1 exactly while in WR_WAIT, and busy SHALL be 1 in either wait state.
REQ-008 ld_mdr_z SHALL load z at the next edge only when in IDLE, and SHALL be ignored while busy.
REQ-009 If ld_mdr_z and wr_start coincide, the newly loaded z SHALL be the value written.
REQ-010 If ld_mdr_z and rd_start coincide, z SHALL be loaded, and the read data SHALL later overwrite it.
REQ-011 mem_ready sampled high in a wait state SHALL return the FSM to IDLE at that edge, and done SHALL be high for the following cycle only.
REQ-012 On read completion, the register SHALL load mem_data_out for a word read.
REQ-013 On read completion of a byte read, the register SHALL load mem_data_out[7:0] in the low byte, with the upper bits set to copies of bit 7 when sign_ext is set, else 0.
REQ-014 In WR_WAIT, mem_data_in SHALL equal the register for a word write, or the register's low byte zero-extended for a byte write; outside WR_WAIT it SHALL be 0.
REQ-015 The wait counter SHALL clear on entry to a wait state and increment each wait cycle without mem_ready.
REQ-016 When the wait counter equals TIMEOUT-1 and mem_ready is low, the FSM SHALL return to IDLE with an err pulse for one cycle, no done pulse, and the register unchanged.
REQ-017 mem_ready on the final allowed cycle SHALL take priority over the timeout.
REQ-018 mem_ready in IDLE SHALL be ignored.
REQ-019 rd_start and wr_start while busy SHALL be ignored and SHALL NOT be queued.
REQ-020 x SHALL be combinational: x equals the register when t_mdr_x=1, else 0, in any state; mdr_q SHALL always equal the register.
REQ-021 Minimum read latency SHALL be 2 edges: start sampled at edge 0, mem_ready sampled at edge 1, register updated and done high after edge 1.

Reset
REQ-022 Reset SHALL asynchronously force IDLE, register=0, counter=0, captured modes=0, and mem_rd=mem_wr=busy=done=err=0.
REQ-023 Reset asserted mid-transfer SHALL abort the transfer immediately, with no done or err pulse and no register update.

Verification (DATA_W=16, TIMEOUT=4)
REQ-024 The bench SHALL cover a word read: rd_start with mem_ready=1 on the next cycle and mem_data_out=16'hBEEF -> mem_rd high 1 cycle, mdr_q=16'hBEEF, done pulses once.
REQ-025 The bench SHALL cover a signed byte read: byte_mode=1, sign_ext=1, mem_data_out=16'h1285 -> mdr_q=16'hFF85; the same with sign_ext=0 -> mdr_q=16'h0085.
REQ-026 The bench SHALL cover a simultaneous load and write: ld_mdr_z=1, z=16'h1234, wr_start=1, byte_mode=0 -> mem_wr=1 with mem_data_in=16'h1234 until mem_ready; with byte_mode=1 -> mem_data_in=16'h0034.
REQ-027 The bench SHALL cover a timeout: rd_start with mem_ready held low -> mem_rd high exactly 4 cycles, err pulses once, mdr_q unchanged, done stays 0; mem_ready on the 4th cycle -> done and no err.
REQ-028 The bench SHALL cover simultaneous starts: rd_start and wr_start together -> RD_WAIT only; wr_start and ld_mdr_z=1, z=16'h5555, while busy -> ignored, mdr_q unchanged.
REQ-029 The bench SHALL cover reset mid-read: reset in RD_WAIT -> mem_rd=0 and mdr_q=0 immediately, with no done or err pulse.

Source files
------------

// File: rtl/mdr_unit.sv
// Memory data register with a small read/write handshake controller.
// The register is loaded either from the internal bus (z) or from memory.
// A read or write is started in IDLE. It completes on mem_ready, or it is
// abandoned after TIMEOUT wait cycles with a one-cycle err pulse.
module mdr_unit #(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] z,
  input  logic              ld_mdr_z,
  input  logic              rd_start,
  input  logic              wr_start,
  input  logic              byte_mode,
  input  logic              sign_ext,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic              t_mdr_x,
  output logic [DATA_W-1:0] x,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] mdr_q
);

  // The counter only has to reach TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] mdr;
  logic [CNT_W-1:0]  wait_cnt;
  logic              byte_q;
  logic              sext_q;
  logic [DATA_W-1:0] wr_src;

  // Widen a byte to DATA_W bits, replicating bit 7 when sext is set.
  // The loop form stays legal when DATA_W is exactly 8.
  function automatic logic [DATA_W-1:0] byte_extend(input logic [7:0] b,
                                                     input logic       sext);
    logic [DATA_W-1:0] r;
    r      = '0;
    r[7:0] = b;
    for (int i = 8; i < DATA_W; i++) begin
      r[i] = sext & b[7];
    end
    return r;
  endfunction

  // Format the register value for the memory write port.
  function automatic logic [DATA_W-1:0] write_format(input logic [DATA_W-1:0] d,
                                                     input logic              bmode);
    return bmode ? byte_extend(d[7:0], 1'b0) : d;
  endfunction

  // Format the memory read data for loading into the register.
  function automatic logic [DATA_W-1:0] read_format(input logic [DATA_W-1:0] d,
                                                    input logic              bmode,
                                                    input logic              sext);
    return bmode ? byte_extend(d[7:0], sext) : d;
  endfunction

  // A load that coincides with a write start must be the value written.
  // So the write data is taken from z instead of the old register.
  assign wr_src = ld_mdr_z ? z : mdr;

  // Controller, data register and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      mdr         <= '0;
      wait_cnt    <= '0;
      byte_q      <= 1'b0;
      sext_q      <= 1'b0;
      mem_data_in <= '0;
      mem_rd      <= 1'b0;
      mem_wr      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ld_mdr_z) begin
            mdr <= z;
          end
          // rd_start has priority. A write that coincides with it is dropped.
          if (rd_start) begin
            state    <= RD_WAIT;
            mem_rd   <= 1'b1;
            busy     <= 1'b1;
            wait_cnt <= '0;
            byte_q   <= byte_mode;
            sext_q   <= sign_ext;
          end else if (wr_start) begin
            state       <= WR_WAIT;
            mem_wr      <= 1'b1;
            busy        <= 1'b1;
            wait_cnt    <= '0;
            byte_q      <= byte_mode;
            sext_q      <= sign_ext;
            mem_data_in <= write_format(wr_src, byte_mode);
          end
        end

        RD_WAIT: begin
          // mem_ready takes priority over the timeout on the last allowed cycle.
          if (mem_ready) begin
            mdr    <= read_format(mem_data_out, byte_q, sext_q);
            state  <= IDLE;
            mem_rd <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
          end else if (wait_cnt == CNT_LAST) begin
            state  <= IDLE;
            mem_rd <= 1'b0;
            busy   <= 1'b0;
            err    <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        WR_WAIT: begin
          // The register is frozen while busy, so mem_data_in needs no refresh.
          if (mem_ready) begin
            state       <= IDLE;
            mem_wr      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            mem_data_in <= '0;
          end else if (wait_cnt == CNT_LAST) begin
            state       <= IDLE;
            mem_wr      <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b1;
            mem_data_in <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        default: begin
          state       <= IDLE;
          mem_rd      <= 1'b0;
          mem_wr      <= 1'b0;
          busy        <= 1'b0;
          mem_data_in <= '0;
        end
      endcase
    end
  end

  // Bus driver and register observation port.
  assign x     = t_mdr_x ? mdr : '0;
  assign mdr_q = mdr;

endmodule

// File: tb/tb_mdr_unit.sv
// Directed bench for mdr_unit with DATA_W=16 and TIMEOUT=4.
module tb_mdr_unit;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] z;
  logic          ld_mdr_z, rd_start, wr_start, byte_mode, sign_ext;
  logic          mem_ready, t_mdr_x;
  logic [DW-1:0] mem_data_out;
  logic [DW-1:0] x, mem_data_in, mdr_q;
  logic          mem_rd, mem_wr, busy, done, err;

  int checks = 0;
  int errors = 0;

  // Pulse counters sampled on the falling edge.
  int rd_cyc = 0, done_cnt = 0, err_cnt = 0;
  int rd0, d0, e0;

  mdr_unit #(.DATA_W(DW), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .z(z), .ld_mdr_z(ld_mdr_z),
    .rd_start(rd_start), .wr_start(wr_start), .byte_mode(byte_mode),
    .sign_ext(sign_ext), .mem_ready(mem_ready), .mem_data_out(mem_data_out),
    .t_mdr_x(t_mdr_x), .x(x), .mem_data_in(mem_data_in), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .busy(busy), .done(done), .err(err), .mdr_q(mdr_q)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_rd) rd_cyc++;
    if (done) done_cnt++;
    if (err) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    rd0 = rd_cyc;
    d0  = done_cnt;
    e0  = err_cnt;
  endtask

  initial begin
    reset = 1'b1; z = '0; ld_mdr_z = 0; rd_start = 0; wr_start = 0;
    byte_mode = 0; sign_ext = 0; mem_ready = 0; t_mdr_x = 0; mem_data_out = '0;
    #2;
    check("rst_mdr", mdr_q, 16'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_rd", mem_rd, 1'b0);
    check("rst_wr", mem_wr, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Word read with minimum latency
    snap();
    rd_start = 1; tick();
    rd_start = 0; mem_ready = 1; mem_data_out = 16'hBEEF;
    check("wr_rd_hi", mem_rd, 1'b1);
    check("wr_busy", busy, 1'b1);
    tick();
    mem_ready = 0;
    check("wr_rd_lo", mem_rd, 1'b0);
    check("wr_mdr", mdr_q, 16'hBEEF);
    check("wr_done", done, 1'b1);
    tick();
    check("wr_done_off", done, 1'b0);
    check("wr_rd_cyc", rd_cyc - rd0, 1);
    check("wr_done_cnt", done_cnt - d0, 1);

    // Bus driver
    t_mdr_x = 1; #1;
    check("x_on", x, 16'hBEEF);
    t_mdr_x = 0; #1;
    check("x_off", x, 16'h0);

    // Signed byte read. Modes change after start to show they were captured.
    byte_mode = 1; sign_ext = 1; rd_start = 1; tick();
    rd_start = 0; byte_mode = 0; sign_ext = 0;
    mem_ready = 1; mem_data_out = 16'h1285; tick();
    mem_ready = 0;
    check("sb_mdr", mdr_q, 16'hFF85);
    // Unsigned byte read
    byte_mode = 1; sign_ext = 0; rd_start = 1; tick();
    rd_start = 0; byte_mode = 0; sign_ext = 1;
    mem_ready = 1; tick();
    mem_ready = 0; sign_ext = 0;
    check("ub_mdr", mdr_q, 16'h0085);

    // Load and word write together
    ld_mdr_z = 1; z = 16'h1234; wr_start = 1; byte_mode = 0; tick();
    ld_mdr_z = 0; wr_start = 0; z = 16'h0;
    check("lw_wr", mem_wr, 1'b1);
    check("lw_data", mem_data_in, 16'h1234);
    check("lw_mdr", mdr_q, 16'h1234);
    tick();
    check("lw_data_hold", mem_data_in, 16'h1234);
    mem_ready = 1; tick();
    mem_ready = 0;
    check("lw_wr_off", mem_wr, 1'b0);
    check("lw_data_off", mem_data_in, 16'h0);
    check("lw_done", done, 1'b1);
    // Load and byte write together
    ld_mdr_z = 1; z = 16'h1234; wr_start = 1; byte_mode = 1; tick();
    ld_mdr_z = 0; wr_start = 0; byte_mode = 0;
    check("lb_data", mem_data_in, 16'h0034);
    mem_ready = 1; tick();
    mem_ready = 0;
    check("lb_mdr", mdr_q, 16'h1234);

    // mem_ready in IDLE is ignored
    mem_ready = 1; mem_data_out = 16'h7777; tick();
    mem_ready = 0;
    check("idle_rdy_busy", busy, 1'b0);
    check("idle_rdy_done", done, 1'b0);
    check("idle_rdy_mdr", mdr_q, 16'h1234);

    // Read timeout
    snap();
    rd_start = 1; tick();
    rd_start = 0;
    tick(); tick(); tick();
    check("to_busy", busy, 1'b1);
    tick();
    check("to_err", err, 1'b1);
    check("to_rd_off", mem_rd, 1'b0);
    tick();
    check("to_err_off", err, 1'b0);
    check("to_rd_cyc", rd_cyc - rd0, 4);
    check("to_err_cnt", err_cnt - e0, 1);
    check("to_done_cnt", done_cnt - d0, 0);
    check("to_mdr", mdr_q, 16'h1234);

    // mem_ready on the final allowed cycle wins over the timeout
    snap();
    rd_start = 1; tick();
    rd_start = 0;
    tick(); tick(); tick();
    mem_ready = 1; mem_data_out = 16'h4321; tick();
    mem_ready = 0;
    check("lr_done", done, 1'b1);
    check("lr_err", err, 1'b0);
    check("lr_mdr", mdr_q, 16'h4321);
    tick();
    check("lr_rd_cyc", rd_cyc - rd0, 4);
    check("lr_err_cnt", err_cnt - e0, 0);

    // Simultaneous starts, then starts and a load while busy
    rd_start = 1; wr_start = 1; tick();
    rd_start = 0; wr_start = 0;
    check("ss_rd", mem_rd, 1'b1);
    check("ss_wr", mem_wr, 1'b0);
    wr_start = 1; ld_mdr_z = 1; z = 16'h5555; tick();
    wr_start = 0; ld_mdr_z = 0;
    check("ss_busy_wr", mem_wr, 1'b0);
    check("ss_busy_mdr", mdr_q, 16'h4321);
    mem_ready = 1; mem_data_out = 16'h0F0F; tick();
    mem_ready = 0;
    check("ss_mdr", mdr_q, 16'h0F0F);
    tick();
    check("ss_noq_busy", busy, 1'b0);
    check("ss_noq_wr", mem_wr, 1'b0);

    // Reset in the middle of a read
    snap();
    rd_start = 1; tick();
    rd_start = 0;
    check("rm_rd_pre", mem_rd, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("rm_rd", mem_rd, 1'b0);
    check("rm_mdr", mdr_q, 16'h0);
    check("rm_busy", busy, 1'b0);
    mem_ready = 1; mem_data_out = 16'hAAAA;
    tick();
    reset = 1'b0; mem_ready = 0;
    tick(); tick();
    check("rm_done_cnt", done_cnt - d0, 0);
    check("rm_err_cnt", err_cnt - e0, 0);
    check("rm_mdr_after", mdr_q, 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
